// File: rtl/psk_sweep_ctl.sv
`default_nettype none
// ============================================================================
// Module      : psk_sweep_ctl
// Description : Search scheduler for the PSK correlator pair. Walks the NCO
//               frequency/phase control words over a programmable grid
//               (phase inner, frequency outer). Each grid point clears the
//               correlators, integrates for WIN_LEN cycles and then has its
//               I/Q energy evaluated. The highest-energy point is kept and
//               handed back to the NCOs when the sweep completes.
// Revision    : 1.0 - initial release
// ============================================================================
module psk_sweep_ctl #(
  parameter int unsigned WIN_LEN = 256,
  parameter logic [11:0] FCW_RST = 12'h100
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] fcw_start,
  input  logic [11:0] fcw_step,
  input  logic [7:0]  fcw_count,
  input  logic [11:0] pcw_step,
  input  logic [3:0]  pcw_count,
  input  logic [7:0]  i_value,
  input  logic [7:0]  q_value,
  output logic [11:0] fcw,
  output logic [11:0] pcw,
  output logic        corr_rst,
  output logic        stb,
  output logic [15:0] energy,
  output logic        busy,
  output logic        done,
  output logic [11:0] best_fcw,
  output logic [11:0] best_pcw,
  output logic [15:0] best_energy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_INTEG = 3'd2,
    S_EVAL  = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [15:0] c_WIN_LAST = 16'(WIN_LEN - 1);

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_win_cnt;
  logic [7:0]  r_row;
  logic [7:0]  r_row_last;
  logic [3:0]  r_col;
  logic [3:0]  r_col_last;
  logic [11:0] r_fcw_step;
  logic [11:0] r_pcw_step;
  logic        r_first;

  logic [11:0] r_fcw;
  logic [11:0] r_pcw;
  logic        r_stb;
  logic [15:0] r_energy;
  logic [11:0] r_best_fcw;
  logic [11:0] r_best_pcw;
  logic [15:0] r_best_energy;

  logic        w_win_end;
  logic        w_col_more;
  logic        w_row_more;
  logic        w_busy;
  logic        w_done;
  logic        w_corr_rst;
  logic [15:0] w_i16;
  logic [15:0] w_q16;
  logic [15:0] w_ii;
  logic [15:0] w_qq;
  logic [15:0] w_energy;

  assign w_win_end  = (r_win_cnt == c_WIN_LAST);
  // Counters never exceed the latched last index, so inequality means "more to go".
  assign w_col_more = (r_col != r_col_last);
  assign w_row_more = (r_row != r_row_last);

  // Squares of sign-extended samples are non-negative and at most 16384, so the
  // low 16 bits of an unsigned multiply are exact and the sum (<= 32768) fits.
  assign w_i16    = {{8{i_value[7]}}, i_value};
  assign w_q16    = {{8{q_value[7]}}, q_value};
  assign w_ii     = w_i16 * w_i16;
  assign w_qq     = w_q16 * w_q16;
  assign w_energy = w_ii + w_qq;

  // State register.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs; abort overrides every transition.
  always_comb begin
    w_next     = r_state;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_corr_rst = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: w_next = S_INTEG;
      S_INTEG: begin
        w_corr_rst = 1'b0;
        if (w_win_end) w_next = S_EVAL;
      end
      S_EVAL: begin
        // Correlators stay out of clear so the sampled sums are stable.
        w_corr_rst = 1'b0;
        w_next     = S_STEP;
      end
      S_STEP: begin
        if (w_col_more || w_row_more) w_next = S_CLEAR;
        else                          w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // Grid walk, window timing, energy evaluation and best-point tracking.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_win_cnt     <= '0;
      r_row         <= '0;
      r_row_last    <= '0;
      r_col         <= '0;
      r_col_last    <= '0;
      r_fcw_step    <= '0;
      r_pcw_step    <= '0;
      r_first       <= 1'b0;
      r_fcw         <= FCW_RST;
      r_pcw         <= '0;
      r_stb         <= 1'b0;
      r_energy      <= '0;
      r_best_fcw    <= '0;
      r_best_pcw    <= '0;
      r_best_energy <= '0;
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_fcw_step <= fcw_step;
            r_pcw_step <= pcw_step;
            r_row_last <= (fcw_count == 8'd0) ? 8'd0 : fcw_count - 8'd1;
            r_col_last <= (pcw_count == 4'd0) ? 4'd0 : pcw_count - 4'd1;
            r_fcw      <= fcw_start;
            r_pcw      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_first    <= 1'b1;
          end
        end
        S_CLEAR: r_win_cnt <= '0;
        S_INTEG: r_win_cnt <= r_win_cnt + 16'd1;
        S_EVAL: begin
          if (!abort) begin
            r_stb    <= 1'b1;
            r_energy <= w_energy;
            r_first  <= 1'b0;
            // Strict compare: on a tie the earlier grid point wins.
            if (r_first || (w_energy > r_best_energy)) begin
              r_best_energy <= w_energy;
              r_best_fcw    <= r_fcw;
              r_best_pcw    <= r_pcw;
            end
          end
        end
        S_STEP: begin
          if (!abort) begin
            if (w_col_more) begin
              r_pcw <= r_pcw + r_pcw_step;
              r_col <= r_col + 4'd1;
            end else if (w_row_more) begin
              r_pcw <= '0;
              r_col <= '0;
              r_fcw <= r_fcw + r_fcw_step;
              r_row <= r_row + 8'd1;
            end
          end
        end
        S_DONE: begin
          // Park the NCOs on the winning point.
          if (!abort) begin
            r_fcw <= r_best_fcw;
            r_pcw <= r_best_pcw;
          end
        end
        default: ;
      endcase
    end
  end

  assign fcw         = r_fcw;
  assign pcw         = r_pcw;
  assign corr_rst    = w_corr_rst;
  assign stb         = r_stb;
  assign energy      = r_energy;
  assign busy        = w_busy;
  assign done        = w_done;
  assign best_fcw    = r_best_fcw;
  assign best_pcw    = r_best_pcw;
  assign best_energy = r_best_energy;

endmodule
`default_nettype wire

// File: tb/tb_psk_sweep_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_psk_sweep_ctl
// Description : Scoreboard bench for psk_sweep_ctl. A reference model expands
//               each sweep's grid into expected NCO words, window energies and
//               the winning point; a monitor pops and compares as the DUT
//               presents them. A correlator stand-in drives I/Q per point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psk_sweep_ctl;

  localparam int W = 4;

  logic        clk;
  logic        rst_in;
  logic        start;
  logic        abort;
  logic [11:0] fcw_start;
  logic [11:0] fcw_step;
  logic [7:0]  fcw_count;
  logic [11:0] pcw_step;
  logic [3:0]  pcw_count;
  logic [7:0]  i_value;
  logic [7:0]  q_value;
  logic [11:0] fcw;
  logic [11:0] pcw;
  logic        corr_rst;
  logic        stb;
  logic [15:0] energy;
  logic        busy;
  logic        done;
  logic [11:0] best_fcw;
  logic [11:0] best_pcw;
  logic [15:0] best_energy;

  psk_sweep_ctl #(.WIN_LEN(W), .FCW_RST(12'h100)) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .abort(abort),
    .fcw_start(fcw_start), .fcw_step(fcw_step), .fcw_count(fcw_count),
    .pcw_step(pcw_step), .pcw_count(pcw_count),
    .i_value(i_value), .q_value(q_value),
    .fcw(fcw), .pcw(pcw), .corr_rst(corr_rst), .stb(stb), .energy(energy),
    .busy(busy), .done(done), .best_fcw(best_fcw), .best_pcw(best_pcw),
    .best_energy(best_energy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-point correlator results, indexed in grid order.
  int iv [0:255];
  int qv [0:255];

  // Scoreboard queues.
  logic [23:0] q_pt[$];     // {fcw,pcw} expected at each window start
  int          q_en[$];     // energy expected at each stb
  int          q_dcyc[$];   // cycle at which done is expected
  logic [39:0] q_dbest[$];  // {best_fcw,best_pcw,best_energy} at done

  // Correlator stand-in: garbage during integration, real result only once
  // the window has run W cycles so an early sample would be noticed.
  int   drv_idx = 0;
  int   drv_cnt = -1;
  logic drv_prev_cr = 1'b1;
  always @(negedge clk) begin
    if (!rst_in || !busy) begin
      drv_idx = 0;
      drv_cnt = -1;
      i_value = 8'h00;
      q_value = 8'h00;
    end else if (!corr_rst && drv_prev_cr) begin
      i_value = 8'($urandom);
      q_value = 8'($urandom);
      drv_cnt = W;
    end else if (drv_cnt > 0) begin
      drv_cnt--;
      if (drv_cnt == 0) begin
        i_value = 8'(iv[drv_idx]);
        q_value = 8'(qv[drv_idx]);
        drv_idx++;
      end
    end
    drv_prev_cr = corr_rst;
  end

  // Monitor: compares every window start, stb and done against the queues.
  logic mon_prev_cr = 1'b1;
  always @(negedge clk) begin
    if (rst_in) begin
      if (busy && !corr_rst && mon_prev_cr) begin
        check("window_expected", 32'(q_pt.size() != 0), 32'd1);
        if (q_pt.size() != 0) check("window_fcw_pcw", {8'd0, fcw, pcw}, {8'd0, q_pt.pop_front()});
      end
      if (stb) begin
        check("stb_expected", 32'(q_en.size() != 0), 32'd1);
        if (q_en.size() != 0) check("energy", {16'd0, energy}, 32'(q_en.pop_front()));
      end
      if (done) begin
        check("done_expected", 32'(q_dcyc.size() != 0), 32'd1);
        if (q_dcyc.size() != 0) begin
          logic [39:0] b;
          b = q_dbest.pop_front();
          check("done_cycle", 32'(cyc), 32'(q_dcyc.pop_front()));
          check("best_fcw", {20'd0, best_fcw}, {20'd0, b[39:28]});
          check("best_pcw", {20'd0, best_pcw}, {20'd0, b[27:16]});
          check("best_energy", {16'd0, best_energy}, {16'd0, b[15:0]});
        end
      end
    end
    mon_prev_cr = corr_rst;
  end

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      iv[i] = 0;
      qv[i] = 0;
    end
  endtask

  task automatic flush_queues();
    q_pt.delete();
    q_en.delete();
    q_dcyc.delete();
    q_dbest.delete();
  endtask

  // Runs one sweep against the model. abort_pt < 0: full sweep; otherwise
  // abort at the middle of that point's integration window.
  task automatic run_sweep(input logic [11:0] fs, input logic [11:0] fst, input logic [7:0] fc,
                           input logic [11:0] pst, input logic [3:0] pc, input int abort_pt);
    int nf, np, npts, k, e, be, seen;
    logic [11:0] bf, bp, f, ph, af, ap;
    bit first;
    nf = (fc == 0) ? 1 : int'(fc);
    np = (pc == 0) ? 1 : int'(pc);
    npts = nf * np;
    first = 1'b1;
    be = 0; bf = 0; bp = 0; af = 0; ap = 0;
    for (int r = 0; r < nf; r++) begin
      for (int c = 0; c < np; c++) begin
        int p;
        p  = r * np + c;
        f  = 12'((int'(fs) + r * int'(fst)) % 4096);
        ph = 12'((c * int'(pst)) % 4096);
        e  = iv[p] * iv[p] + qv[p] * qv[p];
        if (abort_pt < 0 || p <= abort_pt) q_pt.push_back({f, ph});
        if (abort_pt == p) begin af = f; ap = ph; end
        if (abort_pt < 0 || p < abort_pt) begin
          q_en.push_back(e);
          if (first || e > be) begin be = e; bf = f; bp = ph; first = 1'b0; end
        end
      end
    end

    @(negedge clk);
    fcw_start = fs; fcw_step = fst; fcw_count = fc; pcw_step = pst; pcw_count = pc;
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    // Config changes after the start edge must not matter.
    fcw_start = 12'($urandom); fcw_step = 12'($urandom); fcw_count = 8'($urandom);
    pcw_step = 12'($urandom); pcw_count = 4'($urandom);
    if (abort_pt < 0) begin
      q_dcyc.push_back(k + npts * (W + 3));
      q_dbest.push_back({bf, bp, 16'(be)});
    end

    @(negedge clk);
    check("clear_busy", {31'd0, busy}, 32'd1);
    check("clear_corr_rst", {31'd0, corr_rst}, 32'd1);
    @(negedge clk);
    check("integ_corr_rst", {31'd0, corr_rst}, 32'd0);

    if (abort_pt < 0) begin
      seen = 0;
      for (int i = 0; i < npts * (W + 3) + 10; i++) begin
        @(negedge clk);
        if (done) begin seen = 1; break; end
      end
      check("done_seen", 32'(seen), 32'd1);
      if (seen == 1) begin
        @(negedge clk);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("fcw_parked", {20'd0, fcw}, {20'd0, bf});
        check("pcw_parked", {20'd0, pcw}, {20'd0, bp});
      end else begin
        rst_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        flush_queues();
      end
    end else begin
      while (cyc < k + abort_pt * (W + 3) + W / 2) begin
        @(negedge clk);
        if (cyc == k + 3) begin
          fcw_start = 12'hABC; fcw_count = 8'd1; pcw_count = 4'd1;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", {31'd0, busy}, 32'd0);
      check("abort_corr_rst", {31'd0, corr_rst}, 32'd1);
      check("abort_fcw_hold", {20'd0, fcw}, {20'd0, af});
      check("abort_pcw_hold", {20'd0, pcw}, {20'd0, ap});
      check("abort_best_fcw", {20'd0, best_fcw}, {20'd0, bf});
      check("abort_best_pcw", {20'd0, best_pcw}, {20'd0, bp});
      check("abort_best_energy", {16'd0, best_energy}, 32'(be));
      repeat (2 * (W + 3)) @(negedge clk);
      check("abort_still_idle", {31'd0, busy}, 32'd0);
    end
    check("pending_events", 32'(q_pt.size() + q_en.size() + q_dcyc.size()), 32'd0);
    flush_queues();
  endtask

  initial begin
    int k;
    rst_in = 1'b0; start = 1'b0; abort = 1'b0;
    fcw_start = '0; fcw_step = '0; fcw_count = '0; pcw_step = '0; pcw_count = '0;
    clear_tables();

    repeat (3) @(negedge clk);
    check("rst_fcw", {20'd0, fcw}, 32'h100);
    check("rst_pcw", {20'd0, pcw}, 32'd0);
    check("rst_corr_rst", {31'd0, corr_rst}, 32'd1);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_energy", {16'd0, energy}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_best", {8'd0, best_fcw, best_pcw}, 32'd0);
    check("rst_best_energy", {16'd0, best_energy}, 32'd0);
    rst_in = 1'b1;
    @(negedge clk);

    // Single point with zero counts: I=3, Q=-4.
    clear_tables();
    iv[0] = 3; qv[0] = -4;
    run_sweep(12'h345, 12'h010, 8'd0, 12'h020, 4'd0, -1);

    // 3x2 grid with frequency wrap; includes the maximum-energy corner.
    clear_tables();
    iv[0] = 1;    qv[0] = 2;
    iv[1] = -128; qv[1] = -128;
    iv[2] = 127;  qv[2] = -128;
    iv[3] = -5;   qv[3] = 7;
    iv[4] = 0;    qv[4] = 0;
    iv[5] = 100;  qv[5] = -100;
    run_sweep(12'hFFE, 12'h002, 8'd3, 12'h800, 4'd2, -1);

    // Single peak at row 1, col 1 of a 3x3 grid.
    clear_tables();
    iv[4] = 6; qv[4] = 8;
    run_sweep(12'h200, 12'h031, 8'd3, 12'h155, 4'd3, -1);

    // Tie at energy 50: the earlier point is kept.
    clear_tables();
    iv[1] = 5; qv[1] = 5;
    iv[4] = 7; qv[4] = 1;
    run_sweep(12'h010, 12'h100, 8'd2, 12'h0F0, 4'd3, -1);

    // All zero: best is the first point.
    clear_tables();
    run_sweep(12'h777, 12'h001, 8'd2, 12'h002, 4'd2, -1);

    // Abort in the middle of the second point's window, with stray starts.
    clear_tables();
    iv[0] = 9;  qv[0] = 2;
    iv[1] = 11; qv[1] = 0;
    run_sweep(12'h0A0, 12'h010, 8'd2, 12'h300, 4'd2, 1);

    // Randomized sweeps.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 256; i++) begin
        iv[i] = int'($urandom_range(0, 255)) - 128;
        qv[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_sweep(12'($urandom), 12'($urandom), 8'($urandom_range(0, 3)),
                12'($urandom), 4'($urandom_range(0, 4)), -1);
    end

    // Reset in the middle of an integration window.
    clear_tables();
    iv[0] = 20; qv[0] = 20;
    q_pt.push_back({12'h3C0, 12'h000});
    @(negedge clk);
    fcw_start = 12'h3C0; fcw_step = 12'h001; fcw_count = 8'd2; pcw_step = 12'h001; pcw_count = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    while (cyc < k + 2) @(negedge clk);
    rst_in = 1'b0;
    #1;
    check("midrst_fcw", {20'd0, fcw}, 32'h100);
    check("midrst_corr_rst", {31'd0, corr_rst}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_best_energy", {16'd0, best_energy}, 32'd0);
    check("midrst_best", {8'd0, best_fcw, best_pcw}, 32'd0);
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    check("postrst_fcw", {20'd0, fcw}, 32'h100);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_energy", {16'd0, energy}, 32'd0);
    check("postrst_window_seen", 32'(q_pt.size()), 32'd0);
    flush_queues();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
